hilo_ctrl: RTL
==============

Name: hilo_ctrl

Overview:
Sequencer and HI/LO register pair sitting between the control unit and the Booth multiplier. It accepts a MULT request, latches operands, issues the one-cycle start pulse to the multiplier, waits for its stop indication, and captures the 64-bit product into HI/LO. It also services MTHI/MTLO writes and exposes HI/LO for MFHI/MFLO. It provides a busy interlock and a timeout guard to the control unit.

Parameters:
TIMEOUT, 48, max cycles spent in WAIT before aborting (must exceed multiplier latency of 32)
CNT_W, 6, width of the timeout counter (2^CNT_W > TIMEOUT)

Ports:
clk  input  1  system clock, rising edge
Reset  input  1  synchronous, active-high reset
start  input  1  MULT request from control unit, sampled when idle
rs_data  input  32  multiplicand operand / MTHI-MTLO data
rt_data  input  32  multiplier operand
mthi  input  1  write rs_data into HI
mtlo  input  1  write rs_data into LO
mult_a  output  32  registered operand to multiplier input a
mult_b  output  32  registered operand to multiplier input b
multControl  output  1  one-cycle start pulse to multiplier
multStop  input  1  multiplier completion (level; goes high at completion, cleared by next multControl)
mult_hi  input  32  multiplier hi result
mult_lo  input  32  multiplier lo result
hi  output  32  architectural HI
lo  output  32  architectural LO
busy  output  1  high while a multiplication is in flight (ISSUE, ARM, WAIT)
done  output  1  one-cycle pulse after HI/LO captured
timeout  output  1  sticky abort flag, cleared by next accepted start or Reset

Behaviour:
- Reset (sync, active-high): state=IDLE; hi, lo, mult_a, mult_b = 0; multControl, busy, done, timeout = 0; counter = 0. Reset mid-operation aborts with no HI/LO update.
- States: IDLE, ISSUE, ARM, WAIT.
- IDLE: start=1 -> latch mult_a=rs_data, mult_b=rt_data, clear timeout, go ISSUE. Otherwise mthi=1 -> hi<=rs_data; mtlo=1 -> lo<=rs_data (both may fire in the same cycle).
- start and mthi/mtlo asserted together in IDLE: start wins; the moves are dropped.
- ISSUE: multControl=1 for exactly this cycle; go ARM.
- ARM: multStop ignored (multiplier clears its stale flag on the multControl edge); counter=0; go WAIT.
- WAIT: counter increments each cycle. multStop=1 -> hi<=mult_hi, lo<=mult_lo, done=1 next cycle, go IDLE. counter reaches TIMEOUT-1 without multStop -> timeout=1, no HI/LO update, go IDLE.
- busy = (state != IDLE), combinational from state.
- start, mthi, mtlo while busy: ignored. The control unit must stall on busy.
- Latency with the standard multiplier: start sampled at edge E0, multControl sampled by multiplier at E1, multStop rises after E32, HI/LO updated at E33, done high during the cycle after E33. busy deasserts in that same cycle.
- done and multControl are never high for more than one consecutive cycle.
- No arithmetic is performed in this block. The operands are passed unmodified as 32-bit two's complement values.

Optional Feature:
HILO_BYPASS_EN. Defined: hi/lo outputs are combinational bypasses. In the cycle a capture or move is being written, they present the incoming value: mult_hi/mult_lo on a WAIT multStop hit, rs_data on mthi/mtlo. This allows MFHI/MFLO in the same cycle. Undefined: hi/lo come straight from the registers and show new values one cycle after the write edge.

Test Plan:
- Reset, then start with rs=7, rt=-3 (0xFFFFFFFD) -> multControl one pulse at cycle 1; done pulse at cycle 34; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high cycles 1-33.
- start with rs=0x7FFFFFFF, rt=2 -> hi=0x00000000, lo=0xFFFFFFFE. Second start asserted while busy is ignored (single multControl pulse).
- In IDLE: mthi=1 with rs=0xDEADBEEF, then mtlo=1 with rs=0x12345678 -> hi=0xDEADBEEF, lo=0x12345678. mthi+start same cycle -> hi unchanged, multiplication runs.
- Model the multiplier with multStop held 0 -> timeout=1 after TIMEOUT+2 cycles from start; hi/lo unchanged; busy=0. Next start clears timeout.
- Reset asserted in WAIT -> next cycle IDLE; hi=lo=0; done never pulses; later multStop is ignored.
- Stale multStop=1 held high during ISSUE/ARM, then low, then high at cycle 33 -> capture only at cycle 33. With HILO_BYPASS_EN, hi equals mult_hi during the capture cycle.

Source files
------------

// File: rtl/hilo_ctrl.sv
// hilo_ctrl: MULT sequencer for the Booth multiplier plus the architectural HI/LO register pair.
// Optional build macro HILO_BYPASS_EN forwards the value being written onto hi/lo in the write cycle.
module hilo_ctrl #(
  parameter int TIMEOUT = 48,
  parameter int CNT_W   = 6
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        start,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        mthi,
  input  logic        mtlo,
  output logic [31:0] mult_a,
  output logic [31:0] mult_b,
  output logic        multControl,
  input  logic        multStop,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        timeout
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_ARM, S_WAIT} state_t;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      hi_p0;
  logic [31:0]      lo_p0;
  logic [31:0]      hi_nx;
  logic [31:0]      lo_nx;
  logic             accept;
  logic             capture;
  logic             expire;
  logic             hi_we;
  logic             lo_we;
  logic             done_p0;
  logic             timeout_p0;

  assign accept  = (state == S_IDLE) && start;
  assign capture = (state == S_WAIT) && multStop;
  assign expire  = (state == S_WAIT) && !multStop && (cnt == CNT_W'(TIMEOUT - 1));

  // Moves land only in IDLE when no MULT is taken; Reset blocks every write so the
  // bypass path never presents a value that is not actually stored.
  assign hi_we = !Reset && (capture || ((state == S_IDLE) && !start && mthi));
  assign lo_we = !Reset && (capture || ((state == S_IDLE) && !start && mtlo));
  assign hi_nx = capture ? mult_hi : rs_data;
  assign lo_nx = capture ? mult_lo : rs_data;

  always_ff @(posedge clk) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start) state_nx = S_ISSUE;
      S_ISSUE: state_nx = S_ARM;
      S_ARM:   state_nx = S_WAIT;
      S_WAIT:  if (capture || expire) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != S_IDLE);
    multControl = (state == S_ISSUE);
  end

  // Stage p0: timeout counter, done pulse and sticky abort flag
  always_ff @(posedge clk) begin
    if (Reset) begin
      cnt        <= '0;
      done_p0    <= 1'b0;
      timeout_p0 <= 1'b0;
    end else begin
      done_p0 <= capture;
      if (state == S_ARM)       cnt <= '0;
      else if (state == S_WAIT) cnt <= cnt + 1'b1;
      if (accept)      timeout_p0 <= 1'b0;
      else if (expire) timeout_p0 <= 1'b1;
    end
  end

  // Stage p0: operand latches and HI/LO storage
  always_ff @(posedge clk) begin
    if (Reset) begin
      mult_a <= '0;
      mult_b <= '0;
      hi_p0  <= '0;
      lo_p0  <= '0;
    end else begin
      if (accept) begin
        mult_a <= rs_data;
        mult_b <= rt_data;
      end
      if (hi_we) hi_p0 <= hi_nx;
      if (lo_we) lo_p0 <= lo_nx;
    end
  end

  assign done    = done_p0;
  assign timeout = timeout_p0;

`ifdef HILO_BYPASS_EN
  assign hi = hi_we ? hi_nx : hi_p0;
  assign lo = lo_we ? lo_nx : lo_p0;
`else
  assign hi = hi_p0;
  assign lo = lo_p0;
`endif

endmodule
